// File: rtl/evm_tally_unit.sv
// Vote tally engine: poll lifecycle, vote accept/reject with reason codes,
// saturating per-candidate counters and a sequential winner scan.
module evm_tally_unit #(
  parameter int NUM_CANDIDATES = 3,
  parameter int NUM_VOTERS     = 5,
  parameter int CNT_W          = 4,
  parameter int CAND_W         = 2,
  parameter int VOTER_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               open_poll,
  input  logic               close_poll,
  input  logic               vote_signal,
  input  logic [VOTER_W-1:0] voter_number,
  input  logic [CAND_W-1:0]  candidate_number,
  output logic               vote_accepted,
  output logic               vote_rejected,
  output logic [1:0]         reject_code,
  output logic [1:0]         poll_state,
  output logic [VOTER_W:0]   total_votes,
  output logic               overflow,
  output logic               result_valid,
  output logic [CAND_W-1:0]  winner_candidate,
  output logic [CNT_W-1:0]   out_vote,
  output logic               tie
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OPEN = 2'b01;
  localparam logic [1:0] S_SCAN = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q [NUM_CANDIDATES];
  logic [CNT_W-1:0]      cnt_d [NUM_CANDIDATES];
  logic [NUM_VOTERS-1:0] voted_q, voted_d;
  logic [VOTER_W:0]      total_q, total_d;
  logic                  ovf_q, ovf_d;
  logic                  acc_q, acc_d;
  logic                  rej_q, rej_d;
  logic [1:0]            code_q, code_d;
  logic [CAND_W-1:0]     idx_q, idx_d;
  logic [CAND_W-1:0]     win_q, win_d;
  logic [CNT_W-1:0]      max_q, max_d;
  logic                  tie_q, tie_d;

  logic                  scan_last;
  logic                  already;
  logic                  bad_idx;
  logic [1:0]            code;
  logic [CNT_W-1:0]      sel_cnt;
  logic [CNT_W-1:0]      scan_cnt;

  assign scan_last = (idx_q == CAND_W'(NUM_CANDIDATES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (open_poll) state_d = S_OPEN;
      S_OPEN: if (close_poll) state_d = S_SCAN;
      S_SCAN: if (scan_last) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    poll_state       = state_q;
    result_valid     = (state_q == S_DONE);
    winner_candidate = result_valid ? win_q : '0;
    out_vote         = result_valid ? max_q : '0;
    tie              = result_valid & tie_q;
    vote_accepted    = acc_q;
    vote_rejected    = rej_q;
    reject_code      = code_q;
    total_votes      = total_q;
    overflow         = ovf_q;
  end

  // Array lookups by loop so out-of-range indices never address storage
  always_comb begin
    already  = 1'b0;
    sel_cnt  = '0;
    scan_cnt = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if (voter_number == VOTER_W'(i)) already = voted_q[i];
    end
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (candidate_number == CAND_W'(i)) sel_cnt = cnt_q[i];
      if (idx_q == CAND_W'(i)) scan_cnt = cnt_q[i];
    end
  end

  always_comb begin
    bad_idx = (32'(voter_number) >= 32'(NUM_VOTERS)) ||
              (32'(candidate_number) >= 32'(NUM_CANDIDATES));
    if (state_q != S_OPEN)  code = 2'b01;
    else if (bad_idx)       code = 2'b10;
    else if (already)       code = 2'b11;
    else                    code = 2'b00;
    acc_d  = vote_signal && (code == 2'b00);
    rej_d  = vote_signal && (code != 2'b00);
    code_d = vote_signal ? code : 2'b00;
  end

  always_comb begin
    voted_d = voted_q;
    for (int i = 0; i < NUM_CANDIDATES; i++) cnt_d[i] = cnt_q[i];
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if (acc_d && voter_number == VOTER_W'(i)) voted_d[i] = 1'b1;
    end
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (acc_d && candidate_number == CAND_W'(i) &&
          cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    total_d = total_q + (VOTER_W+1)'(acc_d);
    ovf_d   = ovf_q | (acc_d && sel_cnt == CNT_MAX);
  end

  // Strictly-greater replacement keeps the lowest index on ties
  always_comb begin
    idx_d = idx_q;
    win_d = win_q;
    max_d = max_q;
    tie_d = tie_q;
    if (state_q == S_SCAN) begin
      idx_d = scan_last ? idx_q : idx_q + 1'b1;
      if (idx_q == '0) begin
        max_d = scan_cnt;
        win_d = '0;
        tie_d = 1'b0;
      end else if (scan_cnt > max_q) begin
        max_d = scan_cnt;
        win_d = idx_q;
        tie_d = 1'b0;
      end else if (scan_cnt == max_q) begin
        tie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '{default: '0};
      voted_q <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
      code_q  <= 2'b00;
      idx_q   <= '0;
      win_q   <= '0;
      max_q   <= '0;
      tie_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      voted_q <= voted_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      max_q   <= max_d;
      tie_q   <= tie_d;
    end
  end

endmodule

// File: tb/tb_evm_tally_unit.sv
// Bench for evm_tally_unit: directed and random polls against a
// count-based reference model, plus a saturating-counter instance.
module tb_evm_tally_unit;

  localparam int NC = 3;
  localparam int NV = 5;

  logic       clk = 1'b0;
  logic       rst, open_poll, close_poll, vote_signal;
  logic [2:0] voter_number;
  logic [1:0] candidate_number;
  logic       vote_accepted, vote_rejected, result_valid, overflow, tie;
  logic [1:0] reject_code, poll_state, winner_candidate;
  logic [3:0] total_votes, out_vote;

  logic       s_rst, s_open, s_close, s_vote;
  logic [2:0] s_vn;
  logic [1:0] s_cn;
  logic       s_acc, s_rej, s_rv, s_ovf, s_tie;
  logic [1:0] s_code, s_state, s_win;
  logic [3:0] s_total;
  logic [1:0] s_out;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt[NC];
  bit m_voted[NV];
  int m_total, m_state, m_left;
  bit m_ovf;

  always #5 clk = ~clk;

  evm_tally_unit dut (
    .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
    .vote_signal(vote_signal), .voter_number(voter_number),
    .candidate_number(candidate_number), .vote_accepted(vote_accepted),
    .vote_rejected(vote_rejected), .reject_code(reject_code),
    .poll_state(poll_state), .total_votes(total_votes),
    .overflow(overflow), .result_valid(result_valid),
    .winner_candidate(winner_candidate), .out_vote(out_vote), .tie(tie)
  );

  evm_tally_unit #(.NUM_VOTERS(6), .CNT_W(2)) dut_s (
    .clk(clk), .rst(s_rst), .open_poll(s_open), .close_poll(s_close),
    .vote_signal(s_vote), .voter_number(s_vn),
    .candidate_number(s_cn), .vote_accepted(s_acc),
    .vote_rejected(s_rej), .reject_code(s_code),
    .poll_state(s_state), .total_votes(s_total),
    .overflow(s_ovf), .result_valid(s_rv),
    .winner_candidate(s_win), .out_vote(s_out), .tie(s_tie)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    for (int i = 0; i < NV; i++) m_voted[i] = 0;
    m_total = 0; m_state = 0; m_left = 0; m_ovf = 0;
  endtask

  task automatic check_outputs(input bit v, input int code);
    int mx, w, n;
    mx = 0; w = 0; n = 0;
    for (int i = 0; i < NC; i++) if (m_cnt[i] > mx) mx = m_cnt[i];
    for (int i = NC - 1; i >= 0; i--) if (m_cnt[i] == mx) begin
      w = i; n++;
    end
    chk("accepted", 32'(vote_accepted), 32'(v && code == 0));
    chk("rejected", 32'(vote_rejected), 32'(v && code != 0));
    chk("reject_code", 32'(reject_code), v ? 32'(code) : 32'd0);
    chk("poll_state", 32'(poll_state), 32'(m_state));
    chk("total_votes", 32'(total_votes), 32'(m_total));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("result_valid", 32'(result_valid), 32'(m_state == 3));
    chk("winner", 32'(winner_candidate), m_state == 3 ? 32'(w) : 32'd0);
    chk("out_vote", 32'(out_vote), m_state == 3 ? 32'(mx) : 32'd0);
    chk("tie", 32'(tie), 32'(m_state == 3 && n > 1));
  endtask

  // One clock: drive at negedge, model the edge, check at next negedge
  task automatic step(input bit v, input int vn, input int cn,
                      input bit op, input bit cp);
    int code;
    vote_signal = v; voter_number = 3'(vn); candidate_number = 2'(cn);
    open_poll = op; close_poll = cp;
    code = 0;
    if (v) begin
      if (m_state != 1) code = 1;
      else if (vn >= NV || cn >= NC) code = 2;
      else if (m_voted[vn]) code = 3;
      if (code == 0) begin
        m_voted[vn] = 1;
        m_total++;
        if (m_cnt[cn] == 15) m_ovf = 1;
        else m_cnt[cn]++;
      end
    end
    if (m_state == 2) begin
      m_left--;
      if (m_left == 0) m_state = 3;
    end else if (m_state == 0 && op) begin
      m_state = 1;
    end else if (m_state == 1 && cp) begin
      m_state = 2; m_left = NC;
    end
    @(negedge clk);
    vote_signal = 0; open_poll = 0; close_poll = 0;
    check_outputs(v, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    vote_signal = 0; open_poll = 0; close_poll = 0;
    @(negedge clk);
    rst = 0;
    model_clear();
    check_outputs(0, 0);
  endtask

  initial begin
    rst = 0; open_poll = 0; close_poll = 0; vote_signal = 0;
    voter_number = 0; candidate_number = 0;
    s_rst = 1; s_open = 0; s_close = 0; s_vote = 0; s_vn = 0; s_cn = 0;
    @(negedge clk);

    // default flow
    do_reset();
    step(0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 3, 2, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    chk("latency_not_yet", 32'(result_valid), 32'd0);
    idle(1);
    chk("winner_default", 32'(winner_candidate), 32'd1);
    chk("out_vote_default", 32'(out_vote), 32'd2);
    chk("total_default", 32'(total_votes), 32'd4);
    step(0, 0, 0, 1, 0);
    chk("done_holds", 32'(poll_state), 32'd3);

    // rejections
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 5, 0, 0, 0);
    step(1, 0, 3, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("dup_code", 32'(reject_code), 32'd3);
    step(0, 0, 0, 0, 1);
    idle(3);

    // tie and empty polls
    do_reset();
    step(0, 0, 0, 1, 0);
    step(1, 0, 2, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(3);
    chk("tie_low_index", 32'(tie), 32'd1);
    do_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(3);

    // vote on close cycle, then reset mid-scan
    do_reset();
    step(0, 0, 0, 1, 0);
    step(1, 2, 2, 0, 0);
    step(1, 4, 2, 0, 1);
    idle(1);
    do_reset();
    chk("reset_mid_scan", 32'(poll_state), 32'd0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);

    // random polls
    for (int r = 0; r < 6; r++) begin
      do_reset();
      step(1, $urandom_range(0, 7), $urandom_range(0, 3), 0, 0);
      step(0, 0, 0, 1, 0);
      for (int k = 0; k < 14; k++)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
             $urandom_range(0, 3), 0, 0);
      step($urandom_range(0, 1), $urandom_range(0, 5),
           $urandom_range(0, 2), 0, 1);
      for (int k = 0; k < 5; k++)
        step($urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 1), 0);
    end

    // saturation on the narrow-counter instance
    @(negedge clk);
    s_rst = 0; s_open = 1;
    @(negedge clk);
    s_open = 0;
    for (int i = 0; i < 6; i++) begin
      s_vote = 1; s_vn = 3'(i); s_cn = 2'd1;
      @(negedge clk);
      s_vote = 0;
      chk("sat_accept", 32'(s_acc), 32'd1);
    end
    s_close = 1;
    @(negedge clk);
    s_close = 0;
    repeat (3) @(negedge clk);
    chk("sat_valid", 32'(s_rv), 32'd1);
    chk("sat_overflow", 32'(s_ovf), 32'd1);
    chk("sat_out_vote", 32'(s_out), 32'd3);
    chk("sat_total", 32'(s_total), 32'd6);
    chk("sat_winner", 32'(s_win), 32'd1);
    chk("sat_tie", 32'(s_tie), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
